// File: rtl/spi_input_front_end_pkg.sv
// Shared constants for the SPI input front end: channel idle levels,
// channel indices and default debounce sizing.
package spi_input_front_end_pkg;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int DEF_WAIT_TIME     = 3;
  localparam int DEF_COUNTER_WIDTH = 3;

  localparam int NUM_CH  = 3;
  localparam int CH_CS   = 0;
  localparam int CH_SCLK = 1;
  localparam int CH_MOSI = 2;

  // Idle levels packed by channel index, used to seed each conditioner.
  localparam logic [NUM_CH-1:0] CH_INIT = {MOSI_IDLE, SCLK_IDLE, CS_IDLE};

endpackage

// File: rtl/spi_input_front_end_input_conditioner.sv
// One pad channel: 2-flop synchronizer, persistence-counter debounce and
// registered one-cycle edge pulses aligned with the conditioned level change.
module input_conditioner #(
  parameter int   COUNTER_WIDTH = 3,
  parameter int   WAIT_TIME     = 3,
  parameter logic INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic noisy,
  output logic conditioned,
  output logic pos_edge,
  output logic neg_edge
);

  logic                     sync0, sync1;
  logic [COUNTER_WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0       <= INIT;
      sync1       <= INIT;
      conditioned <= INIT;
      cnt         <= '0;
      pos_edge    <= 1'b0;
      neg_edge    <= 1'b0;
    end else begin
      sync0    <= noisy;
      sync1    <= sync0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      // Any return to the current level restarts the persistence count.
      if (sync1 == conditioned) begin
        cnt <= '0;
      end else if (cnt == COUNTER_WIDTH'(WAIT_TIME)) begin
        conditioned <= sync1;
        cnt         <= '0;
        pos_edge    <= sync1;
        neg_edge    <= ~sync1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_input_front_end.sv
// Conditions the raw SPI pads into the clk domain and gates sclk strobes
// to active frames (cs_cond low).
module spi_input_front_end
  import spi_input_front_end_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
  parameter int WAIT_TIME     = DEF_WAIT_TIME
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_raw,
  input  logic cs_raw,
  input  logic mosi_raw,
  output logic cs_cond,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_cond,
  output logic sclk_pos,
  output logic sclk_neg
);

  logic [NUM_CH-1:0] raw, cond, pos, neg;

  assign raw[CH_CS]   = cs_raw;
  assign raw[CH_SCLK] = sclk_raw;
  assign raw[CH_MOSI] = mosi_raw;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    input_conditioner #(
      .COUNTER_WIDTH (COUNTER_WIDTH),
      .WAIT_TIME     (WAIT_TIME),
      .INIT          (CH_INIT[i])
    ) u_cond (
      .clk         (clk),
      .rst_n       (rst_n),
      .noisy       (raw[i]),
      .conditioned (cond[i]),
      .pos_edge    (pos[i]),
      .neg_edge    (neg[i])
    );
  end

  assign cs_cond   = cond[CH_CS];
  assign cs_fall   = neg[CH_CS];
  assign cs_rise   = pos[CH_CS];
  assign mosi_cond = cond[CH_MOSI];

  // Gate on the already-updated cs level: a frame opening on the same edge
  // lets the strobe through, a frame closing on the same edge blocks it.
  assign sclk_pos = pos[CH_SCLK] & ~cond[CH_CS];
  assign sclk_neg = neg[CH_SCLK] & ~cond[CH_CS];

  logic unused_mosi_edges;
  assign unused_mosi_edges = &{1'b0, pos[CH_MOSI], neg[CH_MOSI], cond[CH_SCLK]};

endmodule
